odd_parity_tx: RTL and testbench
================================

# odd_parity_tx

Serial transmitter for the odd-parity serial link. It loads a parallel word, shifts it out MSB-first one bit per clock on a single-bit serial line, then appends one odd-parity bit, so each frame carries an odd number of ones. It is the sending end of the bit stream consumed by the team's serial odd-parity checker, and sits between a parallel word source and that checker.

## Interface
- `WIDTH`, default 8: data bits per frame; must be ≥ 1.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to send `data`; sampled on the rising edge while `ready`=1.
- `data`  in  WIDTH  word to send; captured on the accepting edge only.
- `ready`  out  1  high when a `start` will be accepted.
- `sout`  out  1  serial bit, registered.
- `sout_valid`  out  1  high while `sout` carries a data or parity bit.
- `is_parity`  out  1  high during the parity-bit cycle.
- `done`  out  1  one-cycle pulse in the cycle after the parity bit, when no new frame follows.

## Operation
- States:
  - IDLE: no frame in progress.
  - DATA: WIDTH cycles, one data bit per cycle.
  - PARITY: one cycle, parity bit.
- Accept happens when `start`=1 and `ready`=1. On accept:
  - Shift register loads `data`.
  - Parity register loads `~^data`.
  - Bit counter loads WIDTH-1.
  - State goes to DATA.
- `ready` = (state==IDLE) || (state==PARITY).
- DATA:
  - `sout` = current MSB of the shift register.
  - Shift left by one each cycle; counter decrements.
  - When the counter reaches 0 at the end of a cycle, go to PARITY.
- PARITY:
  - `sout` = stored parity bit, `is_parity`=1.
  - Next state is DATA if a frame is accepted this cycle (back-to-back), else IDLE with `done`=1 for that next cycle.
- Bit order: data[WIDTH-1] first, data[0] last, then parity.
- Parity rule: popcount(data) + parity is odd. All-zero data gives parity 1.
- `start` in DATA is ignored; `data` changes after acceptance have no effect.
- Counter width is $clog2(WIDTH), minimum 1. For WIDTH=1 the frame is one data cycle plus one parity cycle.
- In IDLE: `sout`=0, `sout_valid`=0, `is_parity`=0.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE at once; shift, parity and counter registers clear.
  - Outputs: `sout`=0, `sout_valid`=0, `is_parity`=0, `done`=0, `ready`=1.
  - Reset mid-frame drops the frame; no parity bit or `done` is emitted.
  - After `reset` rises, the first accept can happen on the next rising edge.
- Latency: accepting edge T gives data[WIDTH-1] on `sout` from T to T+1.
  - Data bits occupy cycles T..T+WIDTH-1.
  - Parity occupies cycle T+WIDTH.
  - `done` is high in cycle T+WIDTH+1, unless a frame was accepted at edge T+WIDTH.
- Frame length is WIDTH+1 cycles. Back-to-back frames have no gap: the first data bit of the next frame directly follows the parity bit.
- All outputs are registered or decoded from state only; no combinational path from `start` or `data` to any output.
- `done` and `sout_valid` are never high in the same cycle.

## Test plan
- Reset, then `start` with data=8'hA5 → `sout` = 1,0,1,0,0,1,0,1 then parity 1 (4 ones). `is_parity` is high only in the 9th cycle, then `done` pulses once and `ready`=1.
- data=8'h07 (3 ones) → bits 0,0,0,0,0,1,1,1, parity 0. data=8'h00 → eight 0s, parity 1. data=8'hFF → eight 1s, parity 1.
- Back-to-back: 8'h01 accepted, then `start` with 8'h03 held high during the parity cycle → 18 contiguous valid cycles with parities 0 then 1, no `done` between frames, one `done` after the second frame.
- `start` pulsed with 8'hFF during the 3rd data bit of an 8'h0F frame → ignored: the 8'h0F frame completes intact and no extra frame is sent.
- `reset` low during the 5th data bit, released, then `start` with 8'h80 → all outputs go to reset values immediately with no `done`; the new frame emits 1,0,0,0,0,0,0,0 then parity 0.
- WIDTH=1: data 1 → `sout` 1 then parity 0; data 0 → `sout` 0 then parity 1.

Source files
------------

// File: rtl/odd_parity_tx.sv
// odd_parity_tx: MSB-first serial transmitter with a trailing odd-parity bit.
// Ports: clk, reset (async, active-low), start/data (load request), ready,
//        sout/sout_valid/is_parity (serial stream), done (end-of-burst pulse).
module odd_parity_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             is_parity,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;

    // A new frame may be taken in the parity cycle, which gives
    // gap-free back-to-back frames.
    assign ready  = (state_q == S_IDLE) || (state_q == S_PARITY);
    assign accept = start && ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (accept) begin
            shift_d = data;
            par_d   = ~^data;
            cnt_d   = CNT_LAST;
            state_d = S_DATA;
        end else begin
            case (state_q)
                S_DATA: begin
                    shift_d = shift_q << 1;
                    if (cnt_q == '0) begin
                        state_d = S_PARITY;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_PARITY: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Serial outputs are decoded from registered state only.
    assign sout = ((state_q == S_DATA) && shift_q[WIDTH-1])
                || ((state_q == S_PARITY) && par_q);
    assign sout_valid = (state_q == S_DATA) || (state_q == S_PARITY);
    assign is_parity  = (state_q == S_PARITY);
    assign done       = done_q;

endmodule

// File: tb/tb_odd_parity_tx.sv
// tb_odd_parity_tx: scenario tasks for odd_parity_tx (WIDTH=8 and WIDTH=1)
// against a bit-stream reference model built from popcount and shifts.
module tb_odd_parity_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       st8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       rdy8, so8, sv8, ip8, dn8;

    logic       st1 = 1'b0;
    logic [0:0] d1 = 1'b0;
    logic       rdy1, so1, sv1, ip1, dn1;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    odd_parity_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .data(d8),
        .ready(rdy8), .sout(so8), .sout_valid(sv8),
        .is_parity(ip8), .done(dn8)
    );

    odd_parity_tx #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(st1), .data(d1),
        .ready(rdy1), .sout(so1), .sout_valid(sv1),
        .is_parity(ip1), .done(dn1)
    );

    // Reference: bit i of an 8-bit frame; i=8 is the odd-parity bit.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i >= 8) return (($countones(d) % 2) == 0);
        return d[7-i];
    endfunction

    task automatic test_reset();
        logic [4:0] e;
        e = 5'b00001;
        #2;
        vecs++;
        if ({so8, sv8, ip8, dn8, rdy8} !== e) begin
            errs++;
            $display("FAIL reset8 got=%b exp=%b", {so8, sv8, ip8, dn8, rdy8}, e);
        end
        vecs++;
        if ({so1, sv1, ip1, dn1, rdy1} !== e) begin
            errs++;
            $display("FAIL reset1 got=%b exp=%b", {so1, sv1, ip1, dn1, rdy1}, e);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_frames(input int n_rand);
        logic [7:0] d;
        logic [4:0] e;
        for (int k = 0; k < 4 + n_rand; k++) begin
            case (k)
                0: d = 8'hA5;
                1: d = 8'h07;
                2: d = 8'h00;
                3: d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            st8 = 1'b1;
            d8  = d;
            for (int i = 0; i <= 8; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    st8 = 1'b0;
                    d8  = ~d;
                end
                e = {exp_bit(d, i), 1'b1, i == 8, 1'b0, i == 8};
                vecs++;
                if ({so8, sv8, ip8, dn8, rdy8} !== e) begin
                    errs++;
                    $display("FAIL frame d=%h cyc=%0d got=%b exp=%b",
                             d, i, {so8, sv8, ip8, dn8, rdy8}, e);
                end
            end
            @(negedge clk);
            e = 5'b00011;
            vecs++;
            if ({so8, sv8, ip8, dn8, rdy8} !== e) begin
                errs++;
                $display("FAIL frame_done d=%h got=%b exp=%b",
                         d, {so8, sv8, ip8, dn8, rdy8}, e);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        logic [3:0] e;
        st8 = 1'b1;
        d8  = 8'h01;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) st8 = 1'b0;
            w = (i < 9) ? 8'h01 : 8'h03;
            e = {exp_bit(w, i % 9), 1'b1, (i % 9) == 8, 1'b0};
            vecs++;
            if ({so8, sv8, ip8, dn8} !== e) begin
                errs++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b",
                         i, {so8, sv8, ip8, dn8}, e);
            end
            if (i == 8) begin
                st8 = 1'b1;
                d8  = 8'h03;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = {3'b000, i == 0};
            vecs++;
            if ({so8, sv8, ip8, dn8} !== e) begin
                errs++;
                $display("FAIL b2b_done cyc=%0d got=%b exp=%b",
                         i, {so8, sv8, ip8, dn8}, e);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [3:0] e;
        st8 = 1'b1;
        d8  = 8'h0F;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i == 0 || i == 3) st8 = 1'b0;
            if (i == 2) begin
                st8 = 1'b1;
                d8  = 8'hFF;
            end
            e = {exp_bit(8'h0F, i), 1'b1, i == 8, 1'b0};
            vecs++;
            if ({so8, sv8, ip8, dn8} !== e) begin
                errs++;
                $display("FAIL ignore cyc=%0d got=%b exp=%b",
                         i, {so8, sv8, ip8, dn8}, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = {3'b000, i == 0};
            vecs++;
            if ({so8, sv8, ip8, dn8} !== e) begin
                errs++;
                $display("FAIL ignore_tail cyc=%0d got=%b exp=%b",
                         i, {so8, sv8, ip8, dn8}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        st8 = 1'b1;
        d8  = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) st8 = 1'b0;
            e = {exp_bit(8'hA5, i), 1'b1, 1'b0, 1'b0, 1'b0};
            vecs++;
            if ({so8, sv8, ip8, dn8, rdy8} !== e) begin
                errs++;
                $display("FAIL rmid_pre cyc=%0d got=%b exp=%b",
                         i, {so8, sv8, ip8, dn8, rdy8}, e);
            end
        end
        #1 reset = 1'b0;
        #1;
        e = 5'b00001;
        vecs++;
        if ({so8, sv8, ip8, dn8, rdy8} !== e) begin
            errs++;
            $display("FAIL rmid_async got=%b exp=%b",
                     {so8, sv8, ip8, dn8, rdy8}, e);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vecs++;
            if ({so8, sv8, ip8, dn8, rdy8} !== e) begin
                errs++;
                $display("FAIL rmid_hold cyc=%0d got=%b exp=%b",
                         i, {so8, sv8, ip8, dn8, rdy8}, e);
            end
        end
        reset = 1'b1;
        st8   = 1'b1;
        d8    = 8'h80;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i == 0) st8 = 1'b0;
            if (i <= 8) e = {exp_bit(8'h80, i), 1'b1, i == 8, 1'b0, i == 8};
            else        e = 5'b00011;
            vecs++;
            if ({so8, sv8, ip8, dn8, rdy8} !== e) begin
                errs++;
                $display("FAIL rmid_post cyc=%0d got=%b exp=%b",
                         i, {so8, sv8, ip8, dn8, rdy8}, e);
            end
        end
    endtask

    task automatic test_width1();
        logic       d;
        logic       p;
        logic [4:0] e;
        for (int k = 0; k < 6; k++) begin
            d = (k < 2) ? (k == 0) : 1'($urandom);
            p = (($countones(d) % 2) == 0);
            st1   = 1'b1;
            d1[0] = d;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    st1   = 1'b0;
                    d1[0] = ~d;
                end
                case (i)
                    0:       e = {d, 1'b1, 1'b0, 1'b0, 1'b0};
                    1:       e = {p, 1'b1, 1'b1, 1'b0, 1'b1};
                    default: e = 5'b00011;
                endcase
                vecs++;
                if ({so1, sv1, ip1, dn1, rdy1} !== e) begin
                    errs++;
                    $display("FAIL w1 d=%b cyc=%0d got=%b exp=%b",
                             d, i, {so1, sv1, ip1, dn1, rdy1}, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames(20);
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
